// File: rtl/cdc_req_rx_b_if.sv
// cdc_req_rx_b_if
//   Bundle of the clk_a-facing request/ack signals and the clk_b-facing
//   downstream signals of the receive-side request synchronizer.
//
//   Handshake: the clk_a sender places a word on data_a and flips
//   req_tgl_a. It holds data_a until it sees ack_tgl_b flip. On the
//   receive side, each accepted request produces one vld_out pulse with
//   data_out valid in that cycle. The downstream stage answers with one
//   done_in pulse, which becomes one ack_tgl_b flip.
//
//   Modports:
//     master - sender / downstream side: drives req_tgl_a, data_a, done_in
//     slave  - the synchronizer: drives vld_out, data_out, ack_tgl_b,
//              busy, ovf_err, timeout_err, state_dbg
interface cdc_req_rx_b_if #(
  parameter int DATA_W = 8
);
  logic              req_tgl_a;
  logic [DATA_W-1:0] data_a;
  logic              done_in;
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_tgl_b;
  logic              busy;
  logic              ovf_err;
  logic              timeout_err;
  logic [1:0]        state_dbg;   // FSM state: 0 IDLE, 1 BUSY, 2 ACK

  modport master (
    output req_tgl_a, data_a, done_in,
    input  vld_out, data_out, ack_tgl_b, busy, ovf_err, timeout_err, state_dbg
  );

  modport slave (
    input  req_tgl_a, data_a, done_in,
    output vld_out, data_out, ack_tgl_b, busy, ovf_err, timeout_err, state_dbg
  );
endinterface

// File: rtl/cdc_req_rx_b.sv
// cdc_req_rx_b
//   Receive-side request synchronizer for the clk_b domain.
//   - Synchronizes the toggle-encoded request from clk_a and detects its
//     edge.
//   - Captures data_a and issues a one-cycle vld_out pulse downstream.
//   - Returns a toggle-encoded ack once downstream reports done_in.
//   - Request edges arriving while not IDLE are dropped and latch ovf_err.
//
//   Optional feature macro: CDC_RX_TIMEOUT_EN
//     When defined, BUSY is bounded to TIMEOUT cycles. After that the block
//     forces an ack and latches timeout_err. When undefined, BUSY waits
//     indefinitely and timeout_err is tied to 0.
//
//   Ports:
//     clk_b     - clock
//     reset_in  - asynchronous, active-low reset
//     bus       - cdc_req_rx_b_if.slave
//       in : req_tgl_a, data_a, done_in
//       out: vld_out, data_out, ack_tgl_b, busy, ovf_err, timeout_err,
//            state_dbg
module cdc_req_rx_b #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // minimum 2
  parameter int TIMEOUT     = 16   // minimum 2, timeout build only
) (
  input  logic            clk_b,
  input  logic            reset_in,
  cdc_req_rx_b_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   r_q, r_d;
  logic                   vld_q, vld_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   ack_q, ack_d;
  logic                   ovf_q, ovf_d;
  logic                   req_edge;

`ifdef CDC_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  // History flop r samples the last sync stage every cycle, so each toggle
  // produces exactly one single-cycle edge.
  assign req_edge = sync_q[SYNC_STAGES-1] ^ r_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.req_tgl_a};
    r_d     = sync_q[SYNC_STAGES-1];
    state_d = state_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    ack_d   = ack_q;
    ovf_d   = ovf_q;
`ifdef CDC_RX_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // done_in is ignored here: a stray completion must not ack.
        if (req_edge) begin
          data_d  = bus.data_a;
          vld_d   = 1'b1;
          state_d = ST_BUSY;
`ifdef CDC_RX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_BUSY: begin
        // A new request while busy is dropped; the current ack still goes out.
        if (req_edge) ovf_d = 1'b1;
`ifdef CDC_RX_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (bus.done_in) begin
          ack_d   = ~ack_q;
          state_d = ST_ACK;
        end
`ifdef CDC_RX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d   = ~ack_q;
          to_d    = 1'b1;
          state_d = ST_ACK;
        end
`endif
      end

      ST_ACK: begin
        // One-cycle gap so a capture never directly follows an ack.
        if (req_edge) ovf_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_b or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      r_q     <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      r_q     <= r_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CDC_RX_TIMEOUT_EN
  always_ff @(posedge clk_b or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout_err = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT < 2);
  assign bus.timeout_err    = 1'b0;
`endif

  assign bus.vld_out   = vld_q;
  assign bus.data_out  = data_q;
  assign bus.ack_tgl_b = ack_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cdc_req_rx_b.sv
// tb_cdc_req_rx_b
//   Self-checking bench for cdc_req_rx_b. The reference model tracks the
//   expected ack level as the parity of issued acks. It also keeps the
//   sticky error flags and a queue of words that should appear on vld_out.
module tb_cdc_req_rx_b;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  logic clk_b = 1'b0;
  logic reset_in;
  always #5 clk_b = ~clk_b;

  cdc_req_rx_b_if #(.DATA_W(DATA_W)) bus ();

  cdc_req_rx_b #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_b(clk_b), .reset_in(reset_in), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ack = 1'b0;
  logic              exp_ovf = 1'b0;
  logic              exp_to  = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;
  int                exp_vld  = 0;
  int                vld_seen = 0;

  always @(posedge clk_b) begin
    #1;
    if (bus.vld_out === 1'b1) vld_seen++;
  end

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic drive_req(input logic [DATA_W-1:0] d);
    @(negedge clk_b);
    bus.data_a    = d;
    bus.req_tgl_a = ~bus.req_tgl_a;
  endtask

  task automatic pulse_done();
    @(negedge clk_b);
    bus.done_in = 1'b1;
    @(negedge clk_b);
    bus.done_in = 1'b0;
  endtask

  // Waits (bounded) for vld_out; returns the number of edges it took.
  task automatic wait_vld(output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < SYNC_STAGES + 8) begin
      tick();
      n++;
      if (bus.vld_out === 1'b1) found = 1'b1;
    end
  endtask

  task automatic run_transfer(input logic [DATA_W-1:0] d, input int delay);
    int n;
    bit found;
    drive_req(d);
    exp_q.push_back(d);
    exp_vld++;
    wait_vld(n, found);
    checks++;
    if (!found || n != SYNC_STAGES + 1) begin
      failures++;
      $display("FAIL vld_latency: got %0d edges (found=%0d) need %0d", n, found, SYNC_STAGES + 1);
    end
    if (found) begin
      exp_data = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp_data) begin
        failures++;
        $display("FAIL data_out: got %h need %h", bus.data_out, exp_data);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_at_vld: got %b need 1", bus.busy);
      end
    end
    repeat (delay) tick();
    pulse_done();
    exp_ack = ~exp_ack;
    checks++;
    if ({bus.ack_tgl_b, bus.busy, bus.vld_out} !== {exp_ack, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ack_cycle: got ack/busy/vld=%b%b%b need %b10",
               bus.ack_tgl_b, bus.busy, bus.vld_out, exp_ack);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_ack: got busy=%b need 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    reset_in      = 1'b1;
    bus.req_tgl_a = 1'b0;
    bus.data_a    = '0;
    bus.done_in   = 1'b0;
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if ({bus.vld_out, bus.data_out, bus.ack_tgl_b, bus.busy, bus.ovf_err, bus.timeout_err,
         bus.state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%b data=%h ack=%b busy=%b ovf=%b to=%b st=%0d need all 0",
               bus.vld_out, bus.data_out, bus.ack_tgl_b, bus.busy, bus.ovf_err,
               bus.timeout_err, bus.state_dbg);
    end
    repeat (2) @(negedge clk_b);
    reset_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.ack_tgl_b, bus.vld_out} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle: got busy/ack/vld=%b%b%b need 000",
               bus.busy, bus.ack_tgl_b, bus.vld_out);
    end
  endtask

  task automatic test_single();
    run_transfer(8'hA5, 5);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] fixed [3];
    fixed[0] = 8'h11;
    fixed[1] = 8'h22;
    fixed[2] = 8'h33;
    for (int i = 0; i < 3; i++) run_transfer(fixed[i], $urandom_range(0, 4));
    for (int i = 0; i < 6; i++) run_transfer(DATA_W'($urandom), $urandom_range(0, 6));
    checks++;
    if ({bus.ack_tgl_b, bus.ovf_err} !== {exp_ack, exp_ovf}) begin
      failures++;
      $display("FAIL b2b_state: got ack/ovf=%b%b need %b%b",
               bus.ack_tgl_b, bus.ovf_err, exp_ack, exp_ovf);
    end
  endtask

  task automatic test_stray_done();
    pulse_done();
    repeat (3) tick();
    checks++;
    if ({bus.ack_tgl_b, bus.busy, bus.state_dbg} !== {exp_ack, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL stray_done: got ack=%b busy=%b st=%0d need ack=%b busy=0 st=0",
               bus.ack_tgl_b, bus.busy, bus.state_dbg, exp_ack);
    end
  endtask

  task automatic test_overflow();
    int n;
    bit found;
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom_range(0, 8'h76));
    drive_req(d);
    exp_q.push_back(d);
    exp_vld++;
    wait_vld(n, found);
    if (found) exp_data = exp_q.pop_front();
    drive_req(8'h77);   // violating request: must be dropped
    exp_ovf = 1'b1;
    repeat (SYNC_STAGES + 3) tick();
    checks++;
    if ({bus.ovf_err, bus.data_out, bus.busy} !== {exp_ovf, d, 1'b1}) begin
      failures++;
      $display("FAIL overflow_flag: got ovf=%b data=%h busy=%b need ovf=1 data=%h busy=1",
               bus.ovf_err, bus.data_out, bus.busy, d);
    end
    checks++;
    if (vld_seen != exp_vld) begin
      failures++;
      $display("FAIL overflow_vld_count: got %0d need %0d", vld_seen, exp_vld);
    end
    pulse_done();
    exp_ack = ~exp_ack;
    repeat (6) tick();
    checks++;
    if ({bus.ack_tgl_b, bus.busy, bus.ovf_err} !== {exp_ack, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overflow_single_ack: got ack/busy/ovf=%b%b%b need %b01",
               bus.ack_tgl_b, bus.busy, bus.ovf_err, exp_ack);
    end
    // A legal request after the violation still goes through.
    run_transfer(DATA_W'($urandom), 1);
  endtask

  task automatic test_timeout();
    int n;
    bit found;
    bit stayed_busy;
    drive_req(8'hC3);
    exp_q.push_back(8'hC3);
    exp_vld++;
    wait_vld(n, found);
    if (found) exp_data = exp_q.pop_front();
`ifdef CDC_RX_TIMEOUT_EN
    // vld cycle is BUSY cycle 1; the forced ack lands TIMEOUT edges later.
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i < TIMEOUT) begin
        checks++;
        if (bus.ack_tgl_b !== exp_ack) begin
          failures++;
          $display("FAIL early_timeout: cycle %0d ack=%b need %b", i, bus.ack_tgl_b, exp_ack);
        end
      end
    end
    exp_ack = ~exp_ack;
    exp_to  = 1'b1;
    checks++;
    if ({bus.ack_tgl_b, bus.timeout_err, bus.busy} !== {exp_ack, exp_to, 1'b1}) begin
      failures++;
      $display("FAIL timeout_ack: got ack/to/busy=%b%b%b need %b11",
               bus.ack_tgl_b, bus.timeout_err, bus.busy, exp_ack);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: got busy=%b need 0", bus.busy);
    end
`else
    stayed_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.busy !== 1'b1) stayed_busy = 1'b0;
    end
    checks++;
    if ({stayed_busy, bus.timeout_err, bus.ack_tgl_b} !== {1'b1, exp_to, exp_ack}) begin
      failures++;
      $display("FAIL no_timeout: got stayed_busy=%b to=%b ack=%b need 1 0 %b",
               stayed_busy, bus.timeout_err, bus.ack_tgl_b, exp_ack);
    end
    pulse_done();
    exp_ack = ~exp_ack;
    tick();
    checks++;
    if ({bus.ack_tgl_b, bus.busy} !== {exp_ack, 1'b0}) begin
      failures++;
      $display("FAIL no_timeout_ack: got ack/busy=%b%b need %b0", bus.ack_tgl_b, bus.busy, exp_ack);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    drive_req(DATA_W'($urandom) | 8'h01);
    exp_q.push_back(bus.data_a);
    exp_vld++;
    wait_vld(n, found);
    if (found) exp_data = exp_q.pop_front();
    tick();
    @(negedge clk_b);
    reset_in = 1'b0;
    #1;
    checks++;
    if ({bus.vld_out, bus.data_out, bus.ack_tgl_b, bus.busy, bus.ovf_err, bus.timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got vld=%b data=%h ack=%b busy=%b ovf=%b to=%b need all 0",
               bus.vld_out, bus.data_out, bus.ack_tgl_b, bus.busy, bus.ovf_err, bus.timeout_err);
    end
    bus.req_tgl_a = 1'b0;
    exp_ack = 1'b0;
    exp_ovf = 1'b0;
    exp_to  = 1'b0;
    repeat (2) @(negedge clk_b);
    reset_in = 1'b1;
    tick();
    run_transfer(8'h5A, 2);
    checks++;
    if ({bus.ack_tgl_b, bus.ovf_err, bus.timeout_err} !== {exp_ack, exp_ovf, exp_to}) begin
      failures++;
      $display("FAIL after_reset_transfer: got ack/ovf/to=%b%b%b need %b%b%b",
               bus.ack_tgl_b, bus.ovf_err, bus.timeout_err, exp_ack, exp_ovf, exp_to);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stray_done();
    test_overflow();
    test_timeout();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (vld_seen != exp_vld || exp_q.size() != 0) begin
      failures++;
      $display("FAIL vld_total: got %0d pulses, %0d unmatched, need %0d pulses, 0 unmatched",
               vld_seen, exp_q.size(), exp_vld);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
